ysyx_22050039_store_unit: RTL and testbench

Write-side counterpart of the execute stage's memory-read path. Accepts one RV64 store (Sb/Sh/Sw/Sd) per request and computes the effective address. Aligns data and byte-strobes to the 8-byte memory bus, splitting any access that crosses an 8-byte boundary into two beats. Issues the beats through a valid/ready write channel, waits for each write response, and reports completion to the core.

---
 rtl/ysyx_22050039_store_pkg.sv | 29 ++
 rtl/ysyx_22050039_store_align.sv | 69 ++++++
 rtl/ysyx_22050039_store_unit.sv | 213 +++++++++++++++++++++
 tb/tb_ysyx_22050039_store_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050039_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050039_store_pkg
//  Description : Shared definitions for the RV64 store unit: store-size
//                encodings, memory-beat byte count and the sequencing states.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22050039_store_pkg;

    // Bytes per 64-bit memory beat.
    localparam int MASK_W = 8;

    // req_op encodings: access size is 2^op bytes.
    localparam logic [1:0] SB = 2'd0;
    localparam logic [1:0] SH = 2'd1;
    localparam logic [1:0] SW = 2'd2;
    localparam logic [1:0] SD = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        WAIT0 = 3'd2,
        SEND1 = 3'd3,
        WAIT1 = 3'd4,
        FIN   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_22050039_store_align.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050039_store_align
//  Description : Combinational lane alignment for one store. The access is
//                placed in a 128-bit window starting at the beat-0 base, so
//                the low half is beat 0 and the high half is beat 1.
//  Ports       : op    - store size (SB/SH/SW/SD)
//                off   - byte offset of the effective address in its beat
//                data  - rs2 value (only the low 2^op bytes are used)
//                mask0/data0 - strobes and lane data for beat 0
//                mask1/data1 - strobes and lane data for beat 1
//                split - beat 1 carries at least one byte
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050039_store_align
    import ysyx_22050039_store_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]        op,
    input  logic [2:0]        off,
    input  logic [XLEN-1:0]   data,
    output logic [MASK_W-1:0] mask0,
    output logic [MASK_W-1:0] mask1,
    output logic [XLEN-1:0]   data0,
    output logic [XLEN-1:0]   data1,
    output logic              split
);

    logic [MASK_W-1:0]   w_base_mask;
    logic [XLEN-1:0]     w_data_ext;
    logic [2*MASK_W-1:0] w_full_mask;
    logic [2*XLEN-1:0]   w_full_data;

    // Unused upper bytes of rs2 are cleared so they never reach the bus.
    always_comb begin
        w_base_mask = '0;
        w_data_ext  = '0;
        case (op)
            SB: begin
                w_base_mask = 8'h01;
                w_data_ext  = {{(XLEN-8){1'b0}}, data[7:0]};
            end
            SH: begin
                w_base_mask = 8'h03;
                w_data_ext  = {{(XLEN-16){1'b0}}, data[15:0]};
            end
            SW: begin
                w_base_mask = 8'h0F;
                w_data_ext  = {{(XLEN-32){1'b0}}, data[31:0]};
            end
            default: begin
                w_base_mask = 8'hFF;
                w_data_ext  = data;
            end
        endcase
    end

    assign w_full_mask = {{MASK_W{1'b0}}, w_base_mask} << off;
    assign w_full_data = {{XLEN{1'b0}}, w_data_ext} << {off, 3'b000};

    assign mask0 = w_full_mask[MASK_W-1:0];
    assign mask1 = w_full_mask[2*MASK_W-1:MASK_W];
    assign data0 = w_full_data[XLEN-1:0];
    assign data1 = w_full_data[2*XLEN-1:XLEN];
    assign split = |w_full_mask[2*MASK_W-1:MASK_W];

endmodule
`default_nettype wire

// File: rtl/ysyx_22050039_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050039_store_unit
//  Description : RV64 store unit. Computes the effective address, aligns
//                data/strobes onto the 8-byte bus, splits boundary-crossing
//                stores into two beats, issues each beat on a valid/ready
//                write channel, waits for its response and reports done/err.
//  Ports       : clk, rst (synchronous, active-low)
//                req_valid/req_ready, req_op, req_base, req_offset, req_data
//                mem_wvalid/mem_wready, mem_waddr, mem_wdata, mem_wmask
//                mem_bvalid, mem_berr
//                done (one-cycle pulse), err (qualified by done)
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050039_store_unit
    import ysyx_22050039_store_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [XLEN-1:0]   req_base,
    input  logic [XLEN-1:0]   req_offset,
    input  logic [XLEN-1:0]   req_data,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [XLEN-1:0]   mem_waddr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_bvalid,
    input  logic              mem_berr,
    output logic              done,
    output logic              err
);

    // ------------------------------------------------------------------
    // Address and alignment of the incoming request
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_ea;
    logic [XLEN-1:0]   w_addr0;
    logic [XLEN-1:0]   w_addr1;
    logic [MASK_W-1:0] w_mask0;
    logic [MASK_W-1:0] w_mask1;
    logic [XLEN-1:0]   w_data0;
    logic [XLEN-1:0]   w_data1;
    logic              w_split;

    assign w_ea    = req_base + req_offset;
    assign w_addr0 = {w_ea[XLEN-1:3], 3'b000};
    assign w_addr1 = w_addr0 + XLEN'(8);

    ysyx_22050039_store_align #(
        .XLEN (XLEN)
    ) u_align (
        .op    (req_op),
        .off   (w_ea[2:0]),
        .data  (req_data),
        .mask0 (w_mask0),
        .mask1 (w_mask1),
        .data0 (w_data0),
        .data1 (w_data1),
        .split (w_split)
    );

    // ------------------------------------------------------------------
    // State, beat-1 holding registers and registered outputs
    // ------------------------------------------------------------------
    state_t            r_state,      w_state_nxt;
    logic              r_req_ready,  w_req_ready_nxt;
    logic              r_wvalid,     w_wvalid_nxt;
    logic [XLEN-1:0]   r_waddr,      w_waddr_nxt;
    logic [XLEN-1:0]   r_wdata,      w_wdata_nxt;
    logic [MASK_W-1:0] r_wmask,      w_wmask_nxt;
    logic              r_done,       w_done_nxt;
    logic              r_err,        w_err_nxt;
    logic [XLEN-1:0]   r_b1_addr,    w_b1_addr_nxt;
    logic [XLEN-1:0]   r_b1_data,    w_b1_data_nxt;
    logic [MASK_W-1:0] r_b1_mask,    w_b1_mask_nxt;
    logic              r_split,      w_split_nxt;
    logic              r_err_acc,    w_err_acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_wvalid    <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_b1_addr   <= '0;
            r_b1_data   <= '0;
            r_b1_mask   <= '0;
            r_split     <= 1'b0;
            r_err_acc   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_waddr     <= w_waddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wmask     <= w_wmask_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_b1_addr   <= w_b1_addr_nxt;
            r_b1_data   <= w_b1_data_nxt;
            r_b1_mask   <= w_b1_mask_nxt;
            r_split     <= w_split_nxt;
            r_err_acc   <= w_err_acc_nxt;
        end
    end

    // Every output is computed one cycle ahead so it appears registered in
    // the same cycle the FSM enters the corresponding state.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = r_req_ready;
        w_wvalid_nxt    = r_wvalid;
        w_waddr_nxt     = r_waddr;
        w_wdata_nxt     = r_wdata;
        w_wmask_nxt     = r_wmask;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_b1_addr_nxt   = r_b1_addr;
        w_b1_data_nxt   = r_b1_data;
        w_b1_mask_nxt   = r_b1_mask;
        w_split_nxt     = r_split;
        w_err_acc_nxt   = r_err_acc;

        unique case (r_state)
            IDLE: begin
                w_req_ready_nxt = 1'b1;
                // Acceptance is gated on the registered ready so nothing is
                // taken in the first IDLE cycle after reset.
                if (r_req_ready && req_valid) begin
                    w_req_ready_nxt = 1'b0;
                    w_state_nxt     = SEND0;
                    w_wvalid_nxt    = 1'b1;
                    w_waddr_nxt     = w_addr0;
                    w_wdata_nxt     = w_data0;
                    w_wmask_nxt     = w_mask0;
                    w_b1_addr_nxt   = w_addr1;
                    w_b1_data_nxt   = w_data1;
                    w_b1_mask_nxt   = w_mask1;
                    w_split_nxt     = w_split;
                    w_err_acc_nxt   = 1'b0;
                end
            end
            SEND0: begin
                if (mem_wready) begin
                    w_wvalid_nxt = 1'b0;
                    w_state_nxt  = WAIT0;
                end
            end
            WAIT0: begin
                if (mem_bvalid) begin
                    if (mem_berr) begin
                        // A failed first beat aborts the store; beat 1 is dropped.
                        w_err_acc_nxt = 1'b1;
                        w_state_nxt   = FIN;
                        w_done_nxt    = 1'b1;
                        w_err_nxt     = 1'b1;
                    end else if (r_split) begin
                        w_state_nxt  = SEND1;
                        w_wvalid_nxt = 1'b1;
                        w_waddr_nxt  = r_b1_addr;
                        w_wdata_nxt  = r_b1_data;
                        w_wmask_nxt  = r_b1_mask;
                    end else begin
                        w_state_nxt = FIN;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = r_err_acc;
                    end
                end
            end
            SEND1: begin
                if (mem_wready) begin
                    w_wvalid_nxt = 1'b0;
                    w_state_nxt  = WAIT1;
                end
            end
            WAIT1: begin
                if (mem_bvalid) begin
                    w_err_acc_nxt = r_err_acc | mem_berr;
                    w_state_nxt   = FIN;
                    w_done_nxt    = 1'b1;
                    w_err_nxt     = r_err_acc | mem_berr;
                end
            end
            FIN: begin
                w_state_nxt     = IDLE;
                w_req_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready  = r_req_ready;
    assign mem_wvalid = r_wvalid;
    assign mem_waddr  = r_waddr;
    assign mem_wdata  = r_wdata;
    assign mem_wmask  = r_wmask;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050039_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22050039_store_unit
//  Description : Directed self-checking bench for the RV64 store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050039_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_base;
    logic [63:0] req_offset;
    logic [63:0] req_data;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_bvalid;
    logic        mem_berr;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22050039_store_unit #(
        .XLEN (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_base   (req_base),
        .req_offset (req_offset),
        .req_data   (req_data),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_bvalid (mem_bvalid),
        .mem_berr   (mem_berr),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One store against a memory that is always ready and answers one
    // cycle after each handshake. e0/e1 are the error responses per beat.
    task automatic run_store(input string tag, input logic [1:0] op,
                             input logic [63:0] base, input logic [63:0] off,
                             input logic [63:0] data,
                             input logic [63:0] a0, input logic [7:0] m0, input logic [63:0] d0,
                             input logic split,
                             input logic [63:0] a1, input logic [7:0] m1, input logic [63:0] d1,
                             input logic e0, input logic e1);
        check({tag, ".ready_idle"}, req_ready, 1);
        req_valid  = 1'b1;
        req_op     = op;
        req_base   = base;
        req_offset = off;
        req_data   = data;
        mem_wready = 1'b1;
        tick();
        // Scramble the request inputs: the latched beat must not follow them.
        req_valid  = 1'b0;
        req_op     = ~op;
        req_base   = ~base;
        req_data   = ~data;
        check({tag, ".b0_wvalid"}, mem_wvalid, 1);
        check({tag, ".b0_addr"},   mem_waddr,  a0);
        check({tag, ".b0_mask"},   mem_wmask,  m0);
        check({tag, ".b0_data"},   mem_wdata,  d0);
        check({tag, ".busy"},      req_ready,  0);
        tick();
        check({tag, ".wait0_wvalid"}, mem_wvalid, 0);
        mem_bvalid = 1'b1;
        mem_berr   = e0;
        tick();
        mem_bvalid = 1'b0;
        mem_berr   = 1'b0;
        if (split && !e0) begin
            check({tag, ".b1_wvalid"}, mem_wvalid, 1);
            check({tag, ".b1_addr"},   mem_waddr,  a1);
            check({tag, ".b1_mask"},   mem_wmask,  m1);
            check({tag, ".b1_data"},   mem_wdata,  d1);
            check({tag, ".b1_nodone"}, done,       0);
            tick();
            check({tag, ".wait1_wvalid"}, mem_wvalid, 0);
            mem_bvalid = 1'b1;
            mem_berr   = e1;
            tick();
            mem_bvalid = 1'b0;
            mem_berr   = 1'b0;
        end
        check({tag, ".done"},       done,       1);
        check({tag, ".err"},        err,        e0 | (split & e1));
        check({tag, ".fin_wvalid"}, mem_wvalid, 0);
        tick();
        check({tag, ".done_pulse"}, done,      0);
        check({tag, ".err_clear"},  err,       0);
        check({tag, ".ready_back"}, req_ready, 1);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_base   = '0;
        req_offset = '0;
        req_data   = '0;
        mem_wready = 1'b0;
        mem_bvalid = 1'b0;
        mem_berr   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst.ready",  req_ready,  0);
        check("rst.wvalid", mem_wvalid, 0);
        check("rst.done",   done,       0);
        check("rst.err",    err,        0);
        check("rst.waddr",  mem_waddr,  0);
        check("rst.wdata",  mem_wdata,  0);
        check("rst.wmask",  mem_wmask,  0);
        rst = 1'b1;
        tick();
        check("post_rst.ready", req_ready, 1);

        // ---------------- aligned Sd ----------------
        run_store("sd_aligned", 2'd3, 64'h8000_0000, 64'h10, 64'h1122_3344_5566_7788,
                  64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788,
                  1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0);

        // ---------------- Sb, upper rs2 bytes discarded ----------------
        run_store("sb_lane3", 2'd0, 64'h8000_0003, 64'h0, 64'h1234_5678_9ABC_DEAB,
                  64'h8000_0000, 8'h08, 64'h0000_0000_AB00_0000,
                  1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0);

        // ---------------- split Sw via a negative offset ----------------
        run_store("sw_split", 2'd2, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_DEAD_BEEF,
                  64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000,
                  1'b1, 64'h8000_0008, 8'h03, 64'h0000_0000_0000_DEAD, 1'b0, 1'b0);

        // ---------------- split Sh wrapping at 2^64, beat-1 error ----------------
        run_store("sh_wrap", 2'd1, 64'hFFFF_FFFF_FFFF_FFF0, 64'hF, 64'h0000_0000_0000_A1B2,
                  64'hFFFF_FFFF_FFFF_FFF8, 8'h80, 64'hB200_0000_0000_0000,
                  1'b1, 64'h0, 8'h01, 64'h0000_0000_0000_00A1, 1'b0, 1'b1);

        // ---------------- backpressure ----------------
        check("bp.ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_op     = 2'd1;
        req_base   = 64'h8000_0020;
        req_offset = 64'h0;
        req_data   = 64'h0000_0000_0000_1234;
        mem_wready = 1'b0;
        tick();
        req_valid = 1'b0;
        req_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            check("bp.hold_wvalid", mem_wvalid, 1);
            check("bp.hold_addr",   mem_waddr,  64'h8000_0020);
            check("bp.hold_mask",   mem_wmask,  8'h03);
            check("bp.hold_data",   mem_wdata,  64'h1234);
            check("bp.hold_ready",  req_ready,  0);
            check("bp.hold_done",   done,       0);
            // A stray response while the beat is still pending is ignored.
            mem_bvalid = (i == 1);
            tick();
            mem_bvalid = 1'b0;
        end
        check("bp.last_wvalid", mem_wvalid, 1);
        check("bp.last_addr",   mem_waddr,  64'h8000_0020);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check("bp.wait_wvalid", mem_wvalid, 0);
        check("bp.wait_done0",  done,       0);
        check("bp.wait_ready",  req_ready,  0);
        tick();
        check("bp.wait_done1", done, 0);
        mem_bvalid = 1'b1;
        tick();
        mem_bvalid = 1'b0;
        check("bp.done", done, 1);
        check("bp.err",  err,  0);
        tick();
        check("bp.done_pulse", done,      0);
        check("bp.ready_back", req_ready, 1);

        // ---------------- split Sd with beat-0 error ----------------
        run_store("sd_berr0", 2'd3, 64'h8000_0000, 64'h4, 64'h0102_0304_0506_0708,
                  64'h8000_0000, 8'hF0, 64'h0506_0708_0000_0000,
                  1'b1, 64'h8000_0008, 8'h0F, 64'h0000_0000_0102_0304, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("berr0.no_beat1", mem_wvalid, 0);
            check("berr0.no_done",  done,       0);
            tick();
        end

        // ---------------- reset during WAIT0 of a split store ----------------
        check("mid_rst.ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_op     = 2'd3;
        req_base   = 64'h8000_0000;
        req_offset = 64'h4;
        req_data   = 64'h0102_0304_0506_0708;
        mem_wready = 1'b1;
        tick();
        req_valid = 1'b0;
        check("mid_rst.b0_wvalid", mem_wvalid, 1);
        tick();
        check("mid_rst.wait0", mem_wvalid, 0);
        rst = 1'b0;
        tick();
        check("mid_rst.ready",  req_ready,  0);
        check("mid_rst.wvalid", mem_wvalid, 0);
        check("mid_rst.done",   done,       0);
        check("mid_rst.err",    err,        0);
        check("mid_rst.waddr",  mem_waddr,  0);
        check("mid_rst.wdata",  mem_wdata,  0);
        check("mid_rst.wmask",  mem_wmask,  0);
        rst        = 1'b1;
        mem_bvalid = 1'b1;
        tick();
        mem_bvalid = 1'b0;
        check("mid_rst.late_b_done",   done,       0);
        check("mid_rst.late_b_wvalid", mem_wvalid, 0);
        check("mid_rst.ready_back",    req_ready,  1);
        tick();
        check("mid_rst.still_no_done", done,       0);
        check("mid_rst.still_idle",    mem_wvalid, 0);

        run_store("sh_after_rst", 2'd1, 64'h8000_0000, 64'h2, 64'h0000_0000_0000_5566,
                  64'h8000_0000, 8'h0C, 64'h0000_0000_5566_0000,
                  1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Backstop so a stuck simulation still ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
